// File: rtl/sort8_ctrl_if.sv
// Valid/ready load and unload channels of the batch sorter, plus its status outputs.
interface sort8_ctrl_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [7:0] swap_cnt;

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, swap_cnt
  );

  // Sorter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, swap_cnt
  );
endinterface

// File: rtl/sort8_ctrl.sv
// Batch sorter: loads N 4-bit values, bubble-sorts them ascending with a single
// shared comparator (one compare per cycle, early exit on a swap-free pass),
// then streams them out in order.
module sort8_ctrl #(
  parameter int unsigned N = 8
) (
  input logic         clk,
  input logic         rst_n,
  sort8_ctrl_if.slave bus
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [IdxW-1:0] LastCmp = IdxW'(N - 2);

  typedef enum logic [1:0] {StLoad, StSort, StOut} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] wp_q, wp_d;
  logic [IdxW-1:0] rp_q, rp_d;
  logic [IdxW-1:0] j_q, j_d;
  logic [IdxW-1:0] p_q, p_d;
  logic            sf_q, sf_d;
  logic [7:0]      swap_cnt_q, swap_cnt_d;
  logic [3:0]      mem_q [N];

  logic [IdxW-1:0] j_nxt;
  logic [3:0]      comp_a, comp_b;
  logic            comp_gt;
  logic            load_we, swap_we;

  // The one magnitude comparator, always looking at the adjacent pair mem[j], mem[j+1].
  assign j_nxt   = j_q + IdxW'(1);
  assign comp_a  = mem_q[j_q];
  assign comp_b  = mem_q[j_nxt];
  assign comp_gt = (comp_a > comp_b);

  // State and control register update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      wp_q       <= '0;
      rp_q       <= '0;
      j_q        <= '0;
      p_q        <= '0;
      sf_q       <= 1'b0;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      j_q        <= j_d;
      p_q        <= p_d;
      sf_q       <= sf_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  // Next-state, pointer and swap-count logic.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    j_d        = j_q;
    p_d        = p_q;
    sf_d       = sf_q;
    swap_cnt_d = swap_cnt_q;
    load_we    = 1'b0;
    swap_we    = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (bus.in_valid) begin
          load_we = 1'b1;
          wp_d    = wp_q + IdxW'(1);
          // Count is held from the previous batch until the new batch starts.
          if (wp_q == '0) begin
            swap_cnt_d = '0;
          end
          if (wp_q == LastIdx) begin
            state_d = StSort;
            wp_d    = '0;
            j_d     = '0;
            p_d     = '0;
            sf_d    = 1'b0;
          end
        end
      end

      StSort: begin
        if (comp_gt) begin
          swap_we    = 1'b1;
          sf_d       = 1'b1;
          swap_cnt_d = (swap_cnt_q == 8'hFF) ? swap_cnt_q : swap_cnt_q + 8'd1;
        end
        if (j_q == LastCmp) begin
          // A pass with no swap proves the array sorted; N-1 passes always suffice.
          if ((!sf_q && !comp_gt) || (p_q == LastCmp)) begin
            state_d = StOut;
            rp_d    = '0;
          end else begin
            p_d  = p_q + IdxW'(1);
            j_d  = '0;
            sf_d = 1'b0;
          end
        end else begin
          j_d = j_nxt;
        end
      end

      StOut: begin
        if (bus.out_ready) begin
          rp_d = rp_q + IdxW'(1);
          if (rp_q == LastIdx) begin
            state_d = StLoad;
            wp_d    = '0;
            rp_d    = '0;
          end
        end
      end

      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // Element storage: written by loads and by comparator-driven swaps; not reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_q[wp_q] <= bus.in_data;
    end else if (swap_we) begin
      mem_q[j_q]   <= comp_b;
      mem_q[j_nxt] <= comp_a;
    end
  end

  assign bus.in_ready  = (state_q == StLoad);
  assign bus.busy      = (state_q == StSort);
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_data  = (state_q == StOut) ? mem_q[rp_q] : 4'd0;
  assign bus.swap_cnt  = swap_cnt_q;

endmodule

// File: tb/tb_sort8_ctrl.sv
// Bench for sort8_ctrl: directed and random batches against a counting-sort /
// inversion-count reference, plus a small N=2 instance.
module tb_sort8_ctrl;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sort8_ctrl_if bus ();
  sort8_ctrl_if bus2 ();

  sort8_ctrl #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  sort8_ctrl #(.N(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: sorted output via a histogram, swap count as the inversion count,
  // sort cycles from the largest number of bigger elements preceding any element
  // (bubble sort moves such an element one slot per pass), plus one clean pass,
  // capped at N-1 passes.
  task automatic model(input logic [3:0] v [N], output logic [3:0] s [N],
                       output int unsigned inv, output int unsigned cyc);
    int unsigned hist [16];
    int unsigned k = 0;
    int unsigned mx = 0;
    int unsigned passes;
    inv = 0;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    for (int i = 0; i < N; i++) hist[v[i]]++;
    for (int val = 0; val < 16; val++) begin
      for (int r = 0; r < int'(hist[val]); r++) begin
        s[k] = 4'(val);
        k++;
      end
    end
    for (int i = 0; i < N; i++) begin
      int unsigned lg = 0;
      for (int j = 0; j < i; j++) if (v[j] > v[i]) lg++;
      inv += lg;
      if (lg > mx) mx = lg;
    end
    passes = (mx + 1 < N - 1) ? mx + 1 : N - 1;
    cyc = (N - 1) * passes;
  endtask

  // Loads a batch back-to-back; returns at the negedge of the first cycle after
  // the last accept, with in_valid set to hold.
  task automatic load_vals(input logic [3:0] v [N], input bit hold, input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check({tag, " in_ready during load"}, bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
    end
    @(negedge clk);
    bus.in_valid = hold;
    bus.in_data  = 4'(~v[0]);
  endtask

  // mode 0: out_ready always high; 1: out_ready toggles and in_valid held during
  // SORT; 2: out_ready random.
  task automatic run_batch(input logic [3:0] v [N], input int mode, input string tag);
    logic [3:0]  s [N];
    int unsigned inv, cyc, busy_cyc, idx, guard;
    logic        rdy;
    model(v, s, inv, cyc);
    load_vals(v, (mode == 1), tag);
    busy_cyc = 0;
    while (bus.busy && busy_cyc < 100) begin
      check({tag, " in_ready low in sort"}, bus.in_ready, 0);
      check({tag, " out_valid low in sort"}, bus.out_valid, 0);
      busy_cyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({tag, " sort cycles"}, busy_cyc, cyc);
    check({tag, " swap_cnt"}, bus.swap_cnt, inv);
    idx   = 0;
    guard = 0;
    while (idx < N && guard < 200) begin
      check({tag, " out_valid"}, bus.out_valid, 1);
      check({tag, " out_data"}, bus.out_data, s[idx]);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      guard++;
    end
    bus.out_ready = 1'b0;
    check({tag, " elements delivered"}, idx, N);
    check({tag, " in_ready after out"}, bus.in_ready, 1);
    check({tag, " out_valid after out"}, bus.out_valid, 0);
    check({tag, " out_data after out"}, bus.out_data, 0);
    check({tag, " swap_cnt held"}, bus.swap_cnt, inv);
  endtask

  task automatic run_pair(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    check("n2 in_ready 0", bus2.in_ready, 1);
    bus2.in_valid = 1'b1;
    bus2.in_data  = a;
    @(negedge clk);
    check("n2 in_ready 1", bus2.in_ready, 1);
    bus2.in_data = b;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    check("n2 busy", bus2.busy, 1);
    @(negedge clk);
    check("n2 out_valid", bus2.out_valid, 1);
    check("n2 out_data 0", bus2.out_data, (a > b) ? b : a);
    check("n2 swap_cnt", bus2.swap_cnt, (a > b) ? 1 : 0);
    bus2.out_ready = 1'b1;
    @(negedge clk);
    check("n2 out_data 1", bus2.out_data, (a > b) ? a : b);
    @(negedge clk);
    bus2.out_ready = 1'b0;
    check("n2 in_ready after", bus2.in_ready, 1);
  endtask

  initial begin
    logic [3:0] v [N];
    void'($urandom(32'd20240611));
    bus.in_valid   = 1'b0;
    bus.in_data    = 4'd0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = 4'd0;
    bus2.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset out_data", bus.out_data, 0);
    check("reset swap_cnt", bus.swap_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) v[i] = 4'(i);
    run_batch(v, 0, "ascending");
    for (int i = 0; i < N; i++) v[i] = 4'(N - 1 - i);
    run_batch(v, 0, "descending");
    v = '{4'd5, 4'd3, 4'd5, 4'd3, 4'd15, 4'd0, 4'd15, 4'd0};
    run_batch(v, 0, "duplicates");
    for (int i = 0; i < N; i++) v[i] = 4'($urandom_range(0, 15));
    run_batch(v, 1, "backpressure");

    // Reset in the middle of sorting a reversed batch.
    for (int i = 0; i < N; i++) v[i] = 4'(N - 1 - i);
    load_vals(v, 1'b0, "midreset");
    repeat (9) @(negedge clk);
    check("midreset busy before", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset in_ready", bus.in_ready, 1);
    check("midreset out_valid", bus.out_valid, 0);
    check("midreset busy", bus.busy, 0);
    check("midreset out_data", bus.out_data, 0);
    check("midreset swap_cnt", bus.swap_cnt, 0);
    v[0] = 4'd9;
    v[1] = 4'd1;
    for (int i = 2; i < N; i++) v[i] = 4'($urandom_range(0, 15));
    run_batch(v, 0, "after reset");

    for (int b = 0; b < 200; b++) begin
      bit narrow = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        v[i] = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      run_batch(v, (b % 3 == 0) ? 0 : 2, "random");
    end

    run_pair(4'd3, 4'd3);
    run_pair(4'd15, 4'd0);
    for (int b = 0; b < 30; b++) begin
      run_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
